// File: rtl/ct_f_spsram_pkg.sv
// Shared definitions for the single-port SRAM requester controller.
//   - default address/data widths of the 512x44 SRAM wrapper
//   - controller FSM state encoding
//   - idle (inactive) levels of the active-low SRAM strobes
package ct_f_spsram_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 44;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic CEN_IDLE     = 1'b1;
  localparam logic GWEN_IDLE    = 1'b1;
  localparam logic WEN_IDLE_BIT = 1'b1;

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Read-response FIFO for the SRAM requester controller.
// Synchronous, power-of-2 depth, first-word-fall-through read port.
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   push, push_data : write side
//   pop, pop_data   : read side; pop_data is 0 while empty
//   count/empty/full: occupancy
module ct_f_spsram_rsp_fifo #(
  parameter  int DATA_WIDTH = 44,
  parameter  int RSP_DEPTH  = 4,
  localparam int PW         = $clog2(RSP_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [PW-1:0]                         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                         count_q, count_d;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(RSP_DEPTH));
  // Forced to 0 when empty so the response bus is clean out of reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/ct_f_spsram_req_ctrl.sv
// Requester-side controller for the 512x44 single-port SRAM wrapper.
// Turns a valid/ready read/write request stream into registered SRAM
// strobes and returns read data through a credit-managed response FIFO.
//
// Optional build macro CT_SPSRAM_CLEAR_EN: after reset, zero the whole
// SRAM (one address per cycle, ascending) before accepting requests.
//
// Ports
//   CLK, RST                  : clock, synchronous active-high reset
//   req_vld/req_rdy           : request handshake
//   req_wr/addr/wdata/wmask   : request payload (wmask 1 = write bit)
//   rsp_vld/rsp_rdy/rsp_rdata : read response stream, in read-accept order
//   init_done                 : controller in RUN, requests eligible
//   A/CEN/GWEN/WEN/D          : registered SRAM pins (strobes active low)
//   Q                         : SRAM read data, valid cycle after a read strobe
module ct_f_spsram_req_ctrl
  import ct_f_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  state_e                state_q, state_d;
  logic                  cen_q, cen_d;
  logic                  gwen_q, gwen_d;
  logic [DATA_WIDTH-1:0] wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [1:0]            inflight_q, inflight_d;
  // [0]: read strobe on the pins, [1]: Q holds that read's data.
  logic [1:0]            rd_pipe_q, rd_pipe_d;
`ifdef CT_SPSRAM_CLEAR_EN
  // Extra MSB marks "all addresses written" for the trailing idle cycle.
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
`endif

  logic                  accept, rd_acc, push, pop;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [CW:0]           credit_sum;

  // Every accepted read owns a FIFO slot from accept until it is popped,
  // so the FIFO can never be pushed while full.
  assign credit_sum = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);
  assign req_rdy    = (state_q == ST_RUN) && (credit_sum < (CW+1)'(RSP_DEPTH));
  assign accept     = req_vld && req_rdy;
  assign rd_acc     = accept && !req_wr;
  assign push       = rd_pipe_q[1];
  assign pop        = rsp_vld && rsp_rdy;

  always_comb begin
    state_d    = state_q;
    cen_d      = CEN_IDLE;
    gwen_d     = GWEN_IDLE;
    wen_d      = {DATA_WIDTH{WEN_IDLE_BIT}};
    a_d        = a_q;
    d_d        = d_q;
    rd_pipe_d  = {rd_pipe_q[0], rd_acc};
`ifdef CT_SPSRAM_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
`endif
    case ({rd_acc, push})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_INIT: begin
`ifdef CT_SPSRAM_CLEAR_EN
        // Address 0 is written on the way into CLEAR so strobes run
        // back to back from the first cycle.
        state_d   = ST_CLEAR;
        cen_d     = 1'b0;
        gwen_d    = 1'b0;
        wen_d     = '0;
        a_d       = '0;
        d_d       = '0;
        clr_cnt_d = (ADDR_WIDTH+1)'(1);
`else
        state_d   = ST_RUN;
`endif
      end
`ifdef CT_SPSRAM_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_q[ADDR_WIDTH]) begin
          state_d = ST_RUN;
        end else begin
          cen_d     = 1'b0;
          gwen_d    = 1'b0;
          wen_d     = '0;
          a_d       = clr_cnt_q[ADDR_WIDTH-1:0];
          d_d       = '0;
          clr_cnt_d = clr_cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
`endif
      ST_RUN: begin
        if (accept) begin
          cen_d = 1'b0;
          a_d   = req_addr;
          if (req_wr) begin
            gwen_d = 1'b0;
            wen_d  = ~req_wmask;
            d_d    = req_wdata;
          end else begin
            d_d    = '0;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      cen_q      <= CEN_IDLE;
      gwen_q     <= GWEN_IDLE;
      wen_q      <= {DATA_WIDTH{WEN_IDLE_BIT}};
      a_q        <= '0;
      d_q        <= '0;
      inflight_q <= '0;
      rd_pipe_q  <= '0;
`ifdef CT_SPSRAM_CLEAR_EN
      clr_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cen_q      <= cen_d;
      gwen_q     <= gwen_d;
      wen_q      <= wen_d;
      a_q        <= a_d;
      d_q        <= d_d;
      inflight_q <= inflight_d;
      rd_pipe_q  <= rd_pipe_d;
`ifdef CT_SPSRAM_CLEAR_EN
      clr_cnt_q  <= clr_cnt_d;
`endif
    end
  end

  ct_f_spsram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (Q),
    .pop       (pop),
    .pop_data  (rsp_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rsp_vld   = !fifo_empty;
  assign init_done = (state_q == ST_RUN);
  assign A         = a_q;
  assign CEN       = cen_q;
  assign GWEN      = gwen_q;
  assign WEN       = wen_q;
  assign D         = d_q;

  a_full_blocks_req: assert property (@(posedge CLK) disable iff (RST) fifo_full |-> !req_rdy);
  a_inflight_max:    assert property (@(posedge CLK) disable iff (RST) inflight_q <= 2'd2);

endmodule
